// File: rtl/branch_resolve_unit.sv
// EXE-stage branch resolver: computes the real outcome and target, reports a one-shot
// BResult to train the predictor, and issues a redirect once the delay slot has left IF.
module branch_resolve_unit #(
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXE_Wr,
  input  logic              EXE_Flush,
  input  logic              EXE_Valid,
  input  logic [31:0]       EXE_PC,
  input  logic [3:0]        EXE_BrOp,
  input  logic [4:0]        EXE_RsIdx,
  input  logic [31:0]       EXE_SrcA,
  input  logic [31:0]       EXE_SrcB,
  input  logic [15:0]       EXE_Imm16,
  input  logic [25:0]       EXE_JIdx,
  input  logic              EXE_PTaken,
  input  logic [31:0]       EXE_PTarget,
  input  logic [1:0]        EXE_PCount,
  input  logic              EXE_PHit,
  input  logic              DS_Ready,
  output logic              BR_Valid,
  output logic [31:0]       BR_PC,
  output logic [31:0]       BR_Target,
  output logic              BR_IsTaken,
  output logic              BR_Hit,
  output logic [1:0]        BR_Type,
  output logic [1:0]        BR_Count,
  output logic              Redirect_Valid,
  output logic [31:0]       Redirect_PC,
  output logic [STAT_W-1:0] Stat_Branches,
  output logic [STAT_W-1:0] Stat_Mispredicts
);

  typedef enum logic [0:0] {StIdle, StWaitDs} state_t;

  state_t              r_state, w_state_d;
  logic                r_reported;
  logic [31:0]         r_pend_pc, w_pend_pc_d;
  logic                r_br_valid, r_br_taken, r_br_hit;
  logic [31:0]         r_br_pc, r_br_target;
  logic [1:0]          r_br_type, r_br_count;
  logic                r_rd_valid, w_rd_valid_d;
  logic [31:0]         r_rd_pc, w_rd_pc_d;
  logic [STAT_W-1:0]   r_stat_br, r_stat_mis;

  logic        w_is_br, w_taken, w_resolve, w_mispred;
  logic [1:0]  w_type;
  logic [31:0] w_seq_pc, w_br_tgt, w_j_tgt, w_target, w_correct_pc;

  assign w_seq_pc = EXE_PC + 32'd4;
  assign w_br_tgt = w_seq_pc + {{14{EXE_Imm16[15]}}, EXE_Imm16, 2'b00};
  assign w_j_tgt  = {w_seq_pc[31:28], EXE_JIdx, 2'b00};

  always_comb begin
    w_is_br  = 1'b1;
    w_taken  = 1'b1;
    w_target = w_br_tgt;
    w_type   = 2'b11;
    case (EXE_BrOp)
      4'd1:  w_taken = (EXE_SrcA == EXE_SrcB);
      4'd2:  w_taken = (EXE_SrcA != EXE_SrcB);
      4'd3:  w_taken = !EXE_SrcA[31];
      4'd4:  w_taken = !EXE_SrcA[31] && (EXE_SrcA != 32'd0);
      4'd5:  w_taken = EXE_SrcA[31] || (EXE_SrcA == 32'd0);
      4'd6:  w_taken = EXE_SrcA[31];
      4'd7:  w_target = w_j_tgt;
      4'd8: begin
        w_target = w_j_tgt;
        w_type   = 2'b01;
      end
      4'd9: begin
        w_target = EXE_SrcA;
        w_type   = (EXE_RsIdx == 5'd31) ? 2'b10 : 2'b00;
      end
      4'd10: begin
        w_target = EXE_SrcA;
        w_type   = 2'b01;
      end
      4'd11: begin
        w_taken = !EXE_SrcA[31];
        w_type  = 2'b01;
      end
      4'd12: begin
        w_taken = EXE_SrcA[31];
        w_type  = 2'b01;
      end
      default: begin
        w_is_br  = 1'b0;
        w_taken  = 1'b0;
        w_target = 32'd0;
        w_type   = 2'b00;
      end
    endcase
  end

  assign w_resolve    = EXE_Valid && w_is_br && !r_reported && !EXE_Flush;
  assign w_mispred    = w_resolve &&
                        ((w_taken != EXE_PTaken) || (w_taken && (EXE_PTarget != w_target)));
  assign w_correct_pc = w_taken ? w_target : (EXE_PC + 32'd8);

  // In WAIT_DS a newer mispredict replaces the latched PC before the redirect fires.
  always_comb begin
    w_state_d    = r_state;
    w_pend_pc_d  = r_pend_pc;
    w_rd_valid_d = 1'b0;
    w_rd_pc_d    = r_rd_pc;
    case (r_state)
      StIdle: begin
        if (w_mispred) begin
          if (DS_Ready) begin
            w_rd_valid_d = 1'b1;
            w_rd_pc_d    = w_correct_pc;
          end else begin
            w_pend_pc_d = w_correct_pc;
            w_state_d   = StWaitDs;
          end
        end
      end
      StWaitDs: begin
        if (EXE_Flush) begin
          w_state_d = StIdle;
        end else begin
          if (w_mispred) w_pend_pc_d = w_correct_pc;
          if (DS_Ready) begin
            w_rd_valid_d = 1'b1;
            w_rd_pc_d    = w_pend_pc_d;
            w_state_d    = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pend_pc   <= 32'd0;
      r_rd_valid  <= 1'b0;
      r_rd_pc     <= 32'd0;
      r_reported  <= 1'b0;
      r_br_valid  <= 1'b0;
      r_br_pc     <= 32'd0;
      r_br_target <= 32'd0;
      r_br_taken  <= 1'b0;
      r_br_hit    <= 1'b0;
      r_br_type   <= 2'b00;
      r_br_count  <= 2'b00;
      r_stat_br   <= '0;
      r_stat_mis  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pend_pc  <= w_pend_pc_d;
      r_rd_valid <= w_rd_valid_d;
      r_rd_pc    <= w_rd_pc_d;
      // Advancing EXE means a fresh instruction next cycle, so it wins over set.
      if (EXE_Wr)         r_reported <= 1'b0;
      else if (w_resolve) r_reported <= 1'b1;
      r_br_valid <= w_resolve;
      if (w_resolve) begin
        r_br_pc     <= EXE_PC;
        r_br_target <= w_target;
        r_br_taken  <= w_taken;
        r_br_hit    <= EXE_PHit;
        r_br_type   <= w_type;
        r_br_count  <= EXE_PCount;
        if (r_stat_br != '1) r_stat_br <= r_stat_br + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (w_mispred && (r_stat_mis != '1)) begin
        r_stat_mis <= r_stat_mis + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign BR_Valid         = r_br_valid;
  assign BR_PC            = r_br_pc;
  assign BR_Target        = r_br_target;
  assign BR_IsTaken       = r_br_taken;
  assign BR_Hit           = r_br_hit;
  assign BR_Type          = r_br_type;
  assign BR_Count         = r_br_count;
  assign Redirect_Valid   = r_rd_valid;
  assign Redirect_PC      = r_rd_pc;
  assign Stat_Branches    = r_stat_br;
  assign Stat_Mispredicts = r_stat_mis;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic, all checked every
// cycle against a behavioural model; narrow stat counters make saturation reachable.
module tb_branch_resolve_unit;
  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] SMAX = '1;

  logic clk = 1'b0;
  logic rst, EXE_Wr, EXE_Flush, EXE_Valid, EXE_PTaken, EXE_PHit, DS_Ready;
  logic [31:0] EXE_PC, EXE_SrcA, EXE_SrcB, EXE_PTarget;
  logic [3:0]  EXE_BrOp;
  logic [4:0]  EXE_RsIdx;
  logic [15:0] EXE_Imm16;
  logic [25:0] EXE_JIdx;
  logic [1:0]  EXE_PCount;
  logic        BR_Valid, BR_IsTaken, BR_Hit, Redirect_Valid;
  logic [31:0] BR_PC, BR_Target, Redirect_PC;
  logic [1:0]  BR_Type, BR_Count;
  logic [SW-1:0] Stat_Branches, Stat_Mispredicts;

  branch_resolve_unit #(.STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .EXE_Wr(EXE_Wr), .EXE_Flush(EXE_Flush), .EXE_Valid(EXE_Valid),
    .EXE_PC(EXE_PC), .EXE_BrOp(EXE_BrOp), .EXE_RsIdx(EXE_RsIdx), .EXE_SrcA(EXE_SrcA),
    .EXE_SrcB(EXE_SrcB), .EXE_Imm16(EXE_Imm16), .EXE_JIdx(EXE_JIdx),
    .EXE_PTaken(EXE_PTaken), .EXE_PTarget(EXE_PTarget), .EXE_PCount(EXE_PCount),
    .EXE_PHit(EXE_PHit), .DS_Ready(DS_Ready), .BR_Valid(BR_Valid), .BR_PC(BR_PC),
    .BR_Target(BR_Target), .BR_IsTaken(BR_IsTaken), .BR_Hit(BR_Hit), .BR_Type(BR_Type),
    .BR_Count(BR_Count), .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
    .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_is_br(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd12);
  endfunction

  function automatic bit m_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1:         return a == b;
      4'd2:         return a != b;
      4'd3, 4'd11:  return $signed(a) >= 0;
      4'd6, 4'd12:  return $signed(a) < 0;
      4'd4:         return $signed(a) > 0;
      4'd5:         return $signed(a) <= 0;
      4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [3:0] op, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [15:0] imm,
                                           input logic [25:0] jidx);
    logic [31:0] off;
    off = 32'($signed(imm));
    case (op)
      4'd7, 4'd8:   return ((pc + 32'd4) & 32'hF000_0000) | (32'(jidx) << 2);
      4'd9, 4'd10:  return a;
      default:      return m_is_br(op) ? pc + 32'd4 + off * 32'd4 : 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] m_type(input logic [3:0] op, input logic [4:0] rs);
    if (op == 4'd8 || op == 4'd10 || op == 4'd11 || op == 4'd12) return 2'b01;
    if (op == 4'd9) return (rs == 5'd31) ? 2'b10 : 2'b00;
    if (m_is_br(op)) return 2'b11;
    return 2'b00;
  endfunction

  // Model: expected outputs after each edge, plus pending redirect and reported flag.
  logic        e_brv, e_tk, e_hit, e_rv;
  logic [31:0] e_pc, e_tgt, e_rpc;
  logic [1:0]  e_type, e_cnt;
  int          e_nbr, e_nmis;
  bit          m_reported, m_pending;
  logic [31:0] m_ppc;

  always @(posedge clk) begin : model
    bit res, tk, mis;
    logic [31:0] tgt, cpc;
    if (rst) begin
      e_brv = 0; e_tk = 0; e_hit = 0; e_rv = 0; e_pc = 0; e_tgt = 0; e_rpc = 0;
      e_type = 0; e_cnt = 0; e_nbr = 0; e_nmis = 0;
      m_reported = 0; m_pending = 0; m_ppc = 0;
    end else begin
      res = EXE_Valid && m_is_br(EXE_BrOp) && !m_reported && !EXE_Flush;
      tk  = m_taken(EXE_BrOp, EXE_SrcA, EXE_SrcB);
      tgt = m_target(EXE_BrOp, EXE_PC, EXE_SrcA, EXE_Imm16, EXE_JIdx);
      mis = res && ((tk != EXE_PTaken) || (tk && EXE_PTarget != tgt));
      cpc = tk ? tgt : EXE_PC + 32'd8;
      e_brv = res;
      if (res) begin
        e_pc = EXE_PC; e_tgt = tgt; e_tk = tk; e_hit = EXE_PHit;
        e_type = m_type(EXE_BrOp, EXE_RsIdx); e_cnt = EXE_PCount;
        if (e_nbr < int'(SMAX)) e_nbr++;
      end
      if (mis && e_nmis < int'(SMAX)) e_nmis++;
      e_rv = 0;
      if (m_pending) begin
        if (EXE_Flush) m_pending = 0;
        else begin
          if (mis) m_ppc = cpc;
          if (DS_Ready) begin e_rv = 1; e_rpc = m_ppc; m_pending = 0; end
        end
      end else if (mis) begin
        if (DS_Ready) begin e_rv = 1; e_rpc = cpc; end
        else begin m_pending = 1; m_ppc = cpc; end
      end
      if (EXE_Wr) m_reported = 0;
      else if (res) m_reported = 1;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("BR_Valid", 32'(BR_Valid), 32'(e_brv));
      chk("BR_PC", BR_PC, e_pc);
      chk("BR_Target", BR_Target, e_tgt);
      chk("BR_IsTaken", 32'(BR_IsTaken), 32'(e_tk));
      chk("BR_Hit", 32'(BR_Hit), 32'(e_hit));
      chk("BR_Type", 32'(BR_Type), 32'(e_type));
      chk("BR_Count", 32'(BR_Count), 32'(e_cnt));
      chk("Redirect_Valid", 32'(Redirect_Valid), 32'(e_rv));
      chk("Redirect_PC", Redirect_PC, e_rpc);
      chk("Stat_Branches", 32'(Stat_Branches), 32'(e_nbr));
      chk("Stat_Mispredicts", 32'(Stat_Mispredicts), 32'(e_nmis));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic ds);
    EXE_Valid = 0; EXE_BrOp = 0; EXE_Flush = 0; EXE_Wr = 1; DS_Ready = ds;
  endtask

  task automatic br(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] a,
                    input logic [31:0] b, input logic pt, input logic [31:0] ptgt,
                    input logic ds);
    EXE_Valid = 1; EXE_BrOp = op; EXE_PC = pc; EXE_SrcA = a; EXE_SrcB = b;
    EXE_PTaken = pt; EXE_PTarget = ptgt; DS_Ready = ds; EXE_Flush = 0; EXE_Wr = 1;
  endtask

  initial begin
    int pulses;
    rst = 1; idle(1); EXE_PC = 0; EXE_SrcA = 0; EXE_SrcB = 0; EXE_Imm16 = 0; EXE_JIdx = 0;
    EXE_RsIdx = 0; EXE_PTaken = 0; EXE_PTarget = 0; EXE_PCount = 2'd2; EXE_PHit = 1;
    cyc();
    chk_en = 1;
    chk("rst BR_Valid", 32'(BR_Valid), 0);
    chk("rst Stat_Branches", 32'(Stat_Branches), 0);
    rst = 0;
    cyc();

    // beq taken, correctly predicted
    EXE_Imm16 = 16'h0004;
    br(4'd1, 32'h0040_0010, 32'd5, 32'd5, 1, 32'h0040_0024, 1);
    cyc();
    chk("beq BR_Valid", 32'(BR_Valid), 1);
    chk("beq BR_Target", BR_Target, 32'h0040_0024);
    chk("beq BR_Type", 32'(BR_Type), 32'd3);
    chk("beq BR_IsTaken", 32'(BR_IsTaken), 1);
    chk("beq no redirect", 32'(Redirect_Valid), 0);
    chk("beq Stat_Branches", 32'(Stat_Branches), 1);

    // bne not taken, predicted taken -> redirect to PC+8
    br(4'd2, 32'h0000_0100, 32'd7, 32'd7, 1, 32'h0000_0200, 1);
    cyc();
    chk("bne Redirect_Valid", 32'(Redirect_Valid), 1);
    chk("bne Redirect_PC", Redirect_PC, 32'h0000_0108);
    chk("bne Stat_Mispredicts", 32'(Stat_Mispredicts), 1);
    idle(1);
    cyc();
    chk("bne single pulse", 32'(Redirect_Valid), 0);

    // jal predicted not-taken, delay slot late by 3 cycles
    EXE_JIdx = 26'h0000040;
    br(4'd8, 32'hBFC0_0000, 32'd0, 32'd0, 0, 32'd0, 0);
    cyc();
    chk("jal BR_Type", 32'(BR_Type), 32'd1);
    chk("jal no early redirect", 32'(Redirect_Valid), 0);
    idle(0);
    cyc(); cyc();
    chk("jal still waiting", 32'(Redirect_Valid), 0);
    idle(1);
    cyc();
    chk("jal Redirect_Valid", 32'(Redirect_Valid), 1);
    chk("jal Redirect_PC", Redirect_PC, 32'hB000_0100);
    cyc();
    chk("jal single pulse", 32'(Redirect_Valid), 0);

    // jr $31 stalled in EXE for 4 cycles
    EXE_RsIdx = 5'd31;
    br(4'd9, 32'h0000_3000, 32'h8000_1000, 32'd0, 1, 32'h8000_1000, 1);
    EXE_Wr = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (BR_Valid) pulses++;
    end
    chk("jr pulse count", 32'(pulses), 1);
    chk("jr BR_Type", 32'(BR_Type), 32'd2);
    EXE_Wr = 1;
    cyc();
    chk("jr no report on advance", 32'(BR_Valid), 0);
    EXE_Wr = 0;
    cyc();
    chk("jr reported cleared", 32'(BR_Valid), 1);
    EXE_RsIdx = 0;

    // Pending redirect dropped by flush
    br(4'd1, 32'h0000_0500, 32'd1, 32'd1, 0, 32'd0, 0);
    cyc();
    idle(1); EXE_Flush = 1;
    cyc();
    chk("flush drops redirect", 32'(Redirect_Valid), 0);
    idle(1);
    cyc();
    chk("flush stays idle", 32'(Redirect_Valid), 0);

    // Pending redirect dropped by reset
    br(4'd1, 32'h0000_0600, 32'd1, 32'd1, 0, 32'd0, 0);
    cyc();
    idle(1); rst = 1;
    cyc();
    chk("rst Redirect_Valid", 32'(Redirect_Valid), 0);
    chk("rst Redirect_PC", Redirect_PC, 0);
    chk("rst BR_Target", BR_Target, 0);
    chk("rst Stat_Mispredicts", 32'(Stat_Mispredicts), 0);
    rst = 0;
    cyc();
    chk("rst no late redirect", 32'(Redirect_Valid), 0);

    // Saturate the mispredict counter
    for (int i = 0; i < int'(SMAX) + 3; i++) begin
      br(4'd2, 32'h0000_1000 + 32'(i * 8), 32'd3, 32'd3, 1, 32'h0000_2000, 1);
      cyc();
    end
    chk("sat Stat_Mispredicts", 32'(Stat_Mispredicts), 32'(SMAX));
    chk("sat Stat_Branches", 32'(Stat_Branches), 32'(SMAX));
    idle(1);
    cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      EXE_Valid  = ($urandom_range(0, 9) < 8);
      EXE_BrOp   = 4'($urandom_range(0, 15));
      EXE_PC     = {$urandom_range(0, 32'hFFFF), 14'd0, 2'b00} ^ (32'($urandom) & 32'h3FFC);
      EXE_SrcA   = $urandom;
      case ($urandom_range(0, 3))
        0: EXE_SrcA = 32'd0;
        1: EXE_SrcA = 32'($urandom_range(1, 100));
        default: ;
      endcase
      EXE_SrcB   = ($urandom_range(0, 1) == 1) ? EXE_SrcA : $urandom;
      EXE_Imm16  = 16'($urandom);
      EXE_JIdx   = 26'($urandom);
      EXE_RsIdx  = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom);
      EXE_PTaken = 1'($urandom);
      EXE_PTarget = ($urandom_range(0, 2) != 0) ?
                    m_target(EXE_BrOp, EXE_PC, EXE_SrcA, EXE_Imm16, EXE_JIdx) : $urandom;
      EXE_PCount = 2'($urandom);
      EXE_PHit   = 1'($urandom);
      EXE_Flush  = ($urandom_range(0, 9) == 0);
      EXE_Wr     = ($urandom_range(0, 9) < 6);
      DS_Ready   = ($urandom_range(0, 9) < 6);
      cyc();
    end
    rst = 0; idle(1);
    cyc();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EXE-stage branch resolver, directly downstream of the IF-stage branch predictor.
- Evaluates the real outcome and target of the branch/jump in EXE and compares it with the prediction carried down the pipe.
- Emits a registered one-shot BResult update, which trains the predictor's BHT, counters and RAS.
- On mispredict, issues a registered PC redirect that waits until the delay slot is safe, and keeps branch/mispredict statistics.

Parameters:
- STAT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- EXE_Wr  in  1  EXE register advances this cycle
- EXE_Flush  in  1  EXE instruction cancelled (exception/flush)
- EXE_Valid  in  1  EXE holds a real instruction
- EXE_PC  in  32  PC of EXE instruction
- EXE_BrOp  in  4  0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 j, 8 jal, 9 jr, 10 jalr, 11 bgezal, 12 bltzal; others treated as none
- EXE_RsIdx  in  5  rs register index
- EXE_SrcA, EXE_SrcB  in  32 each  forwarded rs/rt values
- EXE_Imm16  in  16  branch offset
- EXE_JIdx  in  26  jump index
- EXE_PTaken, EXE_PTarget, EXE_PCount, EXE_PHit  in  1/32/2/1  prediction carried from IF
- DS_Ready  in  1  delay-slot instruction has left IF
- BR_Valid  out  1  BResult update pulse
- BR_PC, BR_Target  out  32 each
- BR_IsTaken, BR_Hit  out  1 each
- BR_Type, BR_Count  out  2 each
- Redirect_Valid  out  1  one-cycle redirect pulse
- Redirect_PC  out  32
- Stat_Branches, Stat_Mispredicts  out  STAT_W each

Behaviour:
- Reset: all outputs 0; FSM=IDLE; Reported=0; counters 0. Reset mid-WAIT_DS drops the pending redirect.
- Resolve condition, evaluated combinationally each cycle: EXE_Valid & BrOp≠none & !Reported & !EXE_Flush.
- Reported: set on the resolve cycle, cleared when EXE_Wr=1. A stalled branch reports exactly once.
- Taken: beq A==B; bne A!=B; bgez/bgezal A[31]==0; bltz/bltzal A[31]==1; bgtz !A[31]&&A!=0; blez A[31]||A==0. j/jal/jr/jalr are always taken.
- Target:
  - Conditional branch: PC+4+(sext(Imm16)<<2), mod 2^32.
  - j/jal: {PC+4[31:28],JIdx,2'b00}.
  - jr/jalr: SrcA.
- Type: 01 Call (jal, jalr, bgezal, bltzal); 10 Retn (jr with RsIdx=31); 11 Imme (conditional branches, j); 00 None (other jr).
- BResult: registered at the edge after resolve, BR_Valid high exactly 1 cycle.
  - BR_Target = computed target, even if not taken.
  - BR_Count=EXE_PCount; BR_Hit=EXE_PHit.
  - When no resolve occurs, BR_Valid=0 and other BR_* hold their values.
- Mispredict: Taken≠EXE_PTaken, or (Taken & EXE_PTarget≠Target). Correct PC = Taken ? Target : PC+8.
- FSM IDLE/WAIT_DS:
  - IDLE, resolve with mispredict and DS_Ready=1: next cycle Redirect_Valid=1, Redirect_PC=correct PC; stay IDLE.
  - IDLE, mispredict and DS_Ready=0: latch correct PC, go to WAIT_DS.
  - WAIT_DS with DS_Ready=1: pulse redirect next cycle, go to IDLE.
  - WAIT_DS with EXE_Flush=1: drop pending redirect, go to IDLE. Flush has priority over DS_Ready.
  - A new mispredict resolved in WAIT_DS overrides the latched PC.
- Redirect_Valid is never high two consecutive cycles for one branch.
- Stats: Stat_Branches +1 per resolve; Stat_Mispredicts +1 per mispredict resolve. Both saturate at all-ones, no wrap.
- EXE_Flush in the resolve cycle: no BResult, no redirect, no count.

Test Plan:
- beq, PC=0x0040_0010, A=B=5, Imm16=0x0004, predicted taken to 0x0040_0024, DS_Ready=1 → next cycle BR_Valid=1, BR_Target=0x0040_0024, BR_Type=11, BR_IsTaken=1; no redirect; Stat_Branches=1.
- bne, A=B, predicted taken, PC=0x100, DS_Ready=1 → Redirect_Valid=1, Redirect_PC=0x108; Stat_Mispredicts=1.
- jal, PC=0xBFC0_0000, JIdx=0x0000040, predicted not-taken, DS_Ready=0 for 3 cycles then 1 → FSM enters WAIT_DS; redirect pulse to 0xB000_0100 one cycle after DS_Ready rises; BR_Type=01.
- jr $31, SrcA=0x8000_1000, EXE_Wr=0 for 4 cycles → exactly one BR_Valid pulse, BR_Type=10; Reported clears when EXE_Wr=1.
- Mispredict with DS_Ready=0, then EXE_Flush=1 in WAIT_DS → no redirect, FSM returns to IDLE; separately, rst asserted in WAIT_DS → all outputs 0.
- Preload Stat_Mispredicts to all-ones via forced mispredicts → stays all-ones after a further mispredict.
